// File: rtl/decode_stage.sv
// Decode stage of the multi-cycle MIPS core: it latches the fetched word, reads two
// operands from the register file it owns, and generates main control. Results go into
// output registers and are announced to execute with a one-cycle stage3 pulse.
module decode_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int PC_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stage2,
  input  logic [DATA_W-1:0] instr,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stage3,
  output logic              busy,
  output logic              overrun,
  output logic              illegal,
  output logic [PC_W-1:0]   pc_out,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] imm_ext,
  output logic [25:0]       jtarget,
  output logic [4:0]        shamt,
  output logic [4:0]        dest,
  output logic [2:0]        alu_ctl,
  output logic [6:0]        ctl
);

  typedef enum logic [1:0] {IDLE, READ, ISSUE} state_t;

  // decoded control bundle: {illegal, alu_ctl, ctl}
  typedef struct packed {
    logic       ill;
    logic [2:0] alu;
    logic [6:0] ctl;
  } dec_t;

  state_t                          state, nxt;
  logic [DATA_W-1:0]               instr_q;
  logic [PC_W-1:0]                 pc_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] rf;
  dec_t                            dec;
  logic [DATA_W-1:0]               rs_rd, rt_rd;

  logic [5:0] op, funct;
  logic [4:0] rs_a, rt_a, rd_a;

  assign op    = instr_q[31:26];
  assign rs_a  = instr_q[25:21];
  assign rt_a  = instr_q[20:16];
  assign rd_a  = instr_q[15:11];
  assign funct = instr_q[5:0];
  assign busy  = (state != IDLE);

  // register-file read: r0 and out-of-range read as zero, same-cycle write-back bypassed
  function automatic logic [DATA_W-1:0] rd_port(
    input logic [4:0]                      a,
    input logic                            we,
    input logic [4:0]                      wa,
    input logic [DATA_W-1:0]               wd,
    input logic [NUM_REGS-1:0][DATA_W-1:0] regs
  );
    if (a == 5'd0 || int'(a) >= NUM_REGS) return '0;
    else if (we && wa == a)               return wd;
    else                                  return regs[a];
  endfunction

  // operand reads for the latched word
  always_comb begin
    rs_rd = rd_port(rs_a, wb_en, wb_addr, wb_data, rf);
    rt_rd = rd_port(rt_a, wb_en, wb_addr, wb_data, rf);
  end

  // main control decode; ctl = {reg_write,mem_read,mem_write,alu_src,branch,branch_ne,jump}
  always_comb begin
    dec = '{ill: 1'b0, alu: 3'b000, ctl: 7'b0000000};
    case (op)
      6'b000000: begin
        dec.ctl = 7'b1000000;
        case (funct)
          6'b100000: dec.alu = 3'b010;
          6'b100010: dec.alu = 3'b110;
          6'b100100: dec.alu = 3'b000;
          6'b100101: dec.alu = 3'b001;
          6'b101010: dec.alu = 3'b111;
          6'b000000: dec.alu = 3'b011;
          default:   dec = '{ill: 1'b1, alu: 3'b000, ctl: 7'b0000000};
        endcase
      end
      6'b001000: dec = '{ill: 1'b0, alu: 3'b010, ctl: 7'b1001000};
      6'b100011: dec = '{ill: 1'b0, alu: 3'b010, ctl: 7'b1101000};
      6'b101011: dec = '{ill: 1'b0, alu: 3'b010, ctl: 7'b0011000};
      6'b000100: dec = '{ill: 1'b0, alu: 3'b110, ctl: 7'b0000100};
      6'b000101: dec = '{ill: 1'b0, alu: 3'b110, ctl: 7'b0000110};
      6'b000010: dec = '{ill: 1'b0, alu: 3'b000, ctl: 7'b0000001};
      default:   dec = '{ill: 1'b1, alu: 3'b000, ctl: 7'b0000000};
    endcase
  end

  // FSM next state
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (stage2) nxt = READ;
      READ:    nxt = ISSUE;
      ISSUE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // FSM state, word latch, sticky overrun and the registered stage3 pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      instr_q <= '0;
      pc_q    <= '0;
      overrun <= 1'b0;
      stage3  <= 1'b0;
    end else begin
      state  <= nxt;
      stage3 <= (state == ISSUE);
      if (stage2 && state != IDLE) overrun <= 1'b1;
      if (stage2 && state == IDLE) begin
        instr_q <= instr;
        pc_q    <= pc_in;
      end
    end
  end

  // register file write-back, any state; r0 never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rf <= '0;
    else if (wb_en && wb_addr != 5'd0 && int'(wb_addr) < NUM_REGS) rf[wb_addr] <= wb_data;
  end

  // output registers load in READ and hold until the next decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal <= 1'b0;
      pc_out  <= '0;
      rs_data <= '0;
      rt_data <= '0;
      imm_ext <= '0;
      jtarget <= '0;
      shamt   <= '0;
      dest    <= '0;
      alu_ctl <= '0;
      ctl     <= '0;
    end else if (state == READ) begin
      illegal <= dec.ill;
      pc_out  <= pc_q;
      rs_data <= rs_rd;
      rt_data <= rt_rd;
      imm_ext <= {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};
      jtarget <= instr_q[25:0];
      shamt   <= instr_q[10:6];
      dest    <= (op == 6'b000000) ? rd_a : rt_a;
      alu_ctl <= dec.alu;
      ctl     <= dec.ctl;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a table of decode vectors plus hand-written
// sequences for bypass, overrun and mid-operation reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, stage2, wb_en;
  logic [31:0] instr, wb_data;
  logic [3:0]  pc_in;
  logic [4:0]  wb_addr;
  logic        stage3, busy, overrun, illegal;
  logic [3:0]  pc_out;
  logic [31:0] rs_data, rt_data, imm_ext;
  logic [25:0] jtarget;
  logic [4:0]  shamt, dest;
  logic [2:0]  alu_ctl;
  logic [6:0]  ctl;

  int errors = 0;
  int checks = 0;

  decode_stage #(.DATA_W(32), .NUM_REGS(32), .PC_W(4)) dut (
    .clk(clk), .reset(reset), .stage2(stage2), .instr(instr), .pc_in(pc_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .stage3(stage3), .busy(busy), .overrun(overrun), .illegal(illegal),
    .pc_out(pc_out), .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
    .jtarget(jtarget), .shamt(shamt), .dest(dest), .alu_ctl(alu_ctl), .ctl(ctl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [2:0]  alu;
    logic [6:0]  ctl;
    logic        ill;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  // raise stage2 for one cycle; returns at the negedge where the FSM is in READ
  task automatic issue(input logic [31:0] w, input logic [3:0] pc);
    @(negedge clk);
    stage2 = 1'b1; instr = w; pc_in = pc;
    @(negedge clk);
    stage2 = 1'b0;
  endtask

  // count negedges until stage3 shows, bounded
  task automatic wait_s3(input string name, output int n);
    n = 0;
    while (!stage3 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!stage3) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: got stage3=0 expected stage3=1 within 10 cycles", name);
    end
  endtask

  task automatic check_vec(input string t, input vec_t v);
    check({t, "_pc"},     64'(pc_out),  64'(v.pc));
    check({t, "_rs"},     64'(rs_data), 64'(v.rs));
    check({t, "_rt"},     64'(rt_data), 64'(v.rt));
    check({t, "_imm"},    64'(imm_ext), 64'(v.imm));
    check({t, "_jt"},     64'(jtarget), 64'(v.instr[25:0]));
    check({t, "_shamt"},  64'(shamt),   64'(v.instr[10:6]));
    check({t, "_dest"},   64'(dest),    64'(v.dest));
    check({t, "_alu"},    64'(alu_ctl), 64'(v.alu));
    check({t, "_ctl"},    64'(ctl),     64'(v.ctl));
    check({t, "_ill"},    64'(illegal), 64'(v.ill));
  endtask

  initial begin
    int n;
    int seen;
    vec_t v;

    vecs[0]  = '{32'h00221820, 4'h1, 32'd5, 32'd7, 32'h00001820, 5'd3,  3'b010, 7'b1000000, 1'b0}; // add r3,r1,r2
    vecs[1]  = '{32'h8C24FFFC, 4'h2, 32'd5, 32'd0, 32'hFFFFFFFC, 5'd4,  3'b010, 7'b1101000, 1'b0}; // lw r4,-4(r1)
    vecs[2]  = '{32'h00413022, 4'h3, 32'd7, 32'd5, 32'h00003022, 5'd6,  3'b110, 7'b1000000, 1'b0}; // sub r6,r2,r1
    vecs[3]  = '{32'h00223824, 4'h4, 32'd5, 32'd7, 32'h00003824, 5'd7,  3'b000, 7'b1000000, 1'b0}; // and r7,r1,r2
    vecs[4]  = '{32'h00224025, 4'h5, 32'd5, 32'd7, 32'h00004025, 5'd8,  3'b001, 7'b1000000, 1'b0}; // or r8,r1,r2
    vecs[5]  = '{32'h0022482A, 4'h6, 32'd5, 32'd7, 32'h0000482A, 5'd9,  3'b111, 7'b1000000, 1'b0}; // slt r9,r1,r2
    vecs[6]  = '{32'h00025100, 4'h7, 32'd0, 32'd7, 32'h00005100, 5'd10, 3'b011, 7'b1000000, 1'b0}; // sll r10,r2,4
    vecs[7]  = '{32'h202B8000, 4'h8, 32'd5, 32'd0, 32'hFFFF8000, 5'd11, 3'b010, 7'b1001000, 1'b0}; // addi r11,r1,-32768
    vecs[8]  = '{32'hAC220008, 4'h9, 32'd5, 32'd7, 32'h00000008, 5'd2,  3'b010, 7'b0011000, 1'b0}; // sw r2,8(r1)
    vecs[9]  = '{32'h10220003, 4'hA, 32'd5, 32'd7, 32'h00000003, 5'd2,  3'b110, 7'b0000100, 1'b0}; // beq
    vecs[10] = '{32'h14220003, 4'hB, 32'd5, 32'd7, 32'h00000003, 5'd2,  3'b110, 7'b0000110, 1'b0}; // bne
    vecs[11] = '{32'h08000123, 4'hC, 32'd0, 32'd0, 32'h00000123, 5'd0,  3'b000, 7'b0000001, 1'b0}; // j
    vecs[12] = '{32'hFC000000, 4'hD, 32'd0, 32'd0, 32'h00000000, 5'd0,  3'b000, 7'b0000000, 1'b1}; // op 111111
    vecs[13] = '{32'h0022603F, 4'hE, 32'd5, 32'd7, 32'h0000603F, 5'd12, 3'b000, 7'b0000000, 1'b1}; // bad funct

    reset = 1'b1; stage2 = 1'b0; wb_en = 1'b0; instr = '0; pc_in = '0; wb_addr = '0; wb_data = '0;
    #1;
    check("rst_stage3", 64'(stage3), 64'd0);
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_ovr",    64'(overrun),64'd0);
    check("rst_rs",     64'(rs_data),64'd0);
    check("rst_ctl",    64'(ctl),    64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    wb(5'd1, 32'd5);
    wb(5'd2, 32'd7);

    // table: every supported opcode/funct plus illegal cases
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].instr, vecs[i].pc);
      check($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
      wait_s3($sformatf("v%0d", i), n);
      check($sformatf("v%0d_lat", i), 64'(n), 64'd2);
      check_vec($sformatf("v%0d", i), vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), 64'(stage3), 64'd0);
    end

    // bypass: write r2=9 in the READ cycle of add r3,r1,r2
    issue(32'h00221820, 4'h3);
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd9;
    @(negedge clk);
    wb_en = 1'b0;
    wait_s3("byp", n);
    check("byp_lat", 64'(n), 64'd1);
    check("byp_rs",  64'(rs_data), 64'd5);
    check("byp_rt",  64'(rt_data), 64'd9);

    // r0 stays zero: plain write, then bypass-cycle write to r0
    wb(5'd0, 32'h55);
    issue(32'h00001820, 4'h4);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h66;
    @(negedge clk);
    wb_en = 1'b0;
    wait_s3("r0", n);
    check("r0_rs", 64'(rs_data), 64'd0);
    check("r0_rt", 64'(rt_data), 64'd0);

    // overrun: second stage2 during READ is dropped, one stage3 only
    issue(32'h00221820, 4'h5);
    stage2 = 1'b1; instr = 32'hFC000000; pc_in = 4'hF;
    @(negedge clk);
    stage2 = 1'b0;
    check("ovr_flag", 64'(overrun), 64'd1);
    wait_s3("ovr", n);
    v = '{32'h00221820, 4'h5, 32'd5, 32'd9, 32'h00001820, 5'd3, 3'b010, 7'b1000000, 1'b0};
    check_vec("ovr", v);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (stage3) seen++;
    end
    check("ovr_extra_s3", 64'(seen), 64'd0);
    check("ovr_sticky",   64'(overrun), 64'd1);
    check("hold_rs",      64'(rs_data), 64'd5);
    check("hold_dest",    64'(dest),    64'd3);

    // reset while in READ: outputs clear at once, aborted word never issues
    issue(32'h00221820, 4'h6);
    check("rr_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("rr_rs",    64'(rs_data), 64'd0);
    check("rr_dest",  64'(dest),    64'd0);
    check("rr_ctl",   64'(ctl),     64'd0);
    check("rr_imm",   64'(imm_ext), 64'd0);
    check("rr_busy",  64'(busy),    64'd0);
    check("rr_ovr",   64'(overrun), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (stage3) seen++;
    end
    check("rr_no_s3", 64'(seen), 64'd0);
    issue(32'h00221820, 4'h7);
    wait_s3("rr_after", n);
    v = '{32'h00221820, 4'h7, 32'd0, 32'd0, 32'h00001820, 5'd3, 3'b010, 7'b1000000, 1'b0};
    check_vec("rr_after", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
